// File: rtl/keypad_matrix_responder_pkg.sv
// Shared keypad definitions: FSM state encoding, column strobe codes and the
// key-code to {column,row} map used by both the responder and the scanner decode.
package ttt_pkg;

    typedef enum logic [1:0] {IDLE, ARM, HOLD, GAP} state_e;

    localparam logic [2:0] COL1    = 3'b001;
    localparam logic [2:0] COL2    = 3'b010;
    localparam logic [2:0] COL3    = 3'b100;
    localparam logic [2:0] NO_SCAN = 3'b000;

    localparam logic [3:0] KEY_STAR = 4'd10;
    localparam logic [3:0] KEY_HASH = 4'd11;

    typedef struct packed {
        logic       valid;
        logic [2:0] col;
        logic [3:0] row;
    } colrow_t;

    // Codes 12-15 come back with valid=0 and an all-zero column/row.
    function automatic colrow_t key_to_colrow(input logic [3:0] code);
        colrow_t r;
        r.valid = 1'b1;
        r.col   = NO_SCAN;
        r.row   = 4'b0000;
        case (code)
            4'd1:    begin r.col = COL1; r.row = 4'b0001; end
            4'd4:    begin r.col = COL1; r.row = 4'b0010; end
            4'd7:    begin r.col = COL1; r.row = 4'b0100; end
            KEY_STAR:begin r.col = COL1; r.row = 4'b1000; end
            4'd2:    begin r.col = COL2; r.row = 4'b0001; end
            4'd5:    begin r.col = COL2; r.row = 4'b0010; end
            4'd8:    begin r.col = COL2; r.row = 4'b0100; end
            4'd0:    begin r.col = COL2; r.row = 4'b1000; end
            4'd3:    begin r.col = COL3; r.row = 4'b0001; end
            4'd6:    begin r.col = COL3; r.row = 4'b0010; end
            4'd9:    begin r.col = COL3; r.row = 4'b0100; end
            KEY_HASH:begin r.col = COL3; r.row = 4'b1000; end
            default: r.valid = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/keypad_matrix_responder_if.sv
// Request handshake plus the keypad scan bus (column strobes in, row lines out).
interface keypad_matrix_responder_if;

    logic       req_valid;
    logic [3:0] req_key;
    logic       req_ready;
    logic [2:0] key_col;
    logic [3:0] key_row;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        output req_valid, req_key, key_col,
        input  req_ready, key_row, busy, done, err
    );

    modport slave (
        input  req_valid, req_key, key_col,
        output req_ready, key_row, busy, done, err
    );

endinterface

// File: rtl/keypad_matrix_responder_sync2.sv
// Two-flop synchroniser for the asynchronous column strobes; clears to 0 on reset.
module sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/keypad_matrix_responder.sv
// Emulates a pressed 3x4 keypad key on the scan bus: wait for the key's column,
// drive its row for a hold period, then keep the rows quiet for a gap period.
module keypad_matrix_responder
    import ttt_pkg::*;
#(
    parameter int HOLD_CYCLES    = 250000,
    parameter int GAP_CYCLES     = 250000,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                       clk,
    input  logic                       rst,
    keypad_matrix_responder_if.slave   bus
);

    localparam int MAX_HG = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int MAX_C  = (MAX_HG > TIMEOUT_CYCLES) ? MAX_HG : TIMEOUT_CYCLES;
    localparam int CW     = (MAX_C > 1) ? $clog2(MAX_C) : 1;

    localparam logic [CW-1:0] HOLD_LAST    = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST     = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [2:0]    colq;
    colrow_t       req_cr;

    state_e        state_q,   state_d;
    logic [CW-1:0] cnt_q,     cnt_d;
    logic [2:0]    tcol_q,    tcol_d;
    logic [3:0]    trow_q,    trow_d;
    logic [3:0]    key_row_q, key_row_d;
    logic          done_q,    done_d;
    logic          err_q,     err_d;

    sync2 #(.W(3)) u_col_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.key_col),
        .q   (colq)
    );

    always_comb begin
        req_cr    = key_to_colrow(bus.req_key);
        state_d   = state_q;
        cnt_d     = cnt_q;
        tcol_d    = tcol_q;
        trow_d    = trow_q;
        key_row_d = 4'b0000;
        done_d    = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    if (req_cr.valid) begin
                        state_d = ARM;
                        cnt_d   = '0;
                        tcol_d  = req_cr.col;
                        trow_d  = req_cr.row;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ARM: begin
                if (colq == tcol_q) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    err_d   = 1'b1;
                    state_d = GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD: begin
                // Row follows the column match; it is still driven on the last
                // HOLD cycle and drops on the first edge inside GAP.
                key_row_d = (colq == tcol_q) ? trow_q : 4'b0000;
                if (cnt_q == HOLD_LAST) begin
                    state_d = GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            tcol_q    <= NO_SCAN;
            trow_q    <= 4'b0000;
            key_row_q <= 4'b0000;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tcol_q    <= tcol_d;
            trow_q    <= trow_d;
            key_row_q <= key_row_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.key_row   = key_row_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;

endmodule
